hilo_unit: RTL and testbench

- Next-generation HI/LO block for the MIPS pipeline.
- Owns the architectural HI/LO registers and writes them at WB commit.
- Resolves EX-stage HI/LO reads against a parametrised number of in-flight producer stages, selecting each half independently.
- Contains an iterative radix-2 divider for DIV/DIVU with a start/busy/done handshake, so EX can stall while a divide runs.

---
 rtl/hilo_unit.sv | 172 +++++++++++++++++
 tb/tb_hilo_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - MIPS HI/LO registers with per-half EX forwarding and an iterative radix-2 divider.
// Optional macro HILO_DIV_ZERO_EN adds div_zero and a one-cycle zero-divisor path.
module hilo_unit #(
    parameter int DW   = 32,
    parameter int NFWD = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           ex_read,
    input  logic [2*NFWD-1:0]    fwd_mode,
    input  logic [DW*NFWD-1:0]   fwd_hi,
    input  logic [DW*NFWD-1:0]   fwd_lo,
    input  logic [1:0]           wb_mode,
    input  logic [DW-1:0]        wb_hi,
    input  logic [DW-1:0]        wb_lo,
    output logic [2*DW-1:0]      real_hilo,
    input  logic                 div_start,
    input  logic                 div_signed,
    input  logic [DW-1:0]        div_a,
    input  logic [DW-1:0]        div_b,
    input  logic                 div_flush,
    output logic                 div_busy,
    output logic                 div_done,
    output logic [DW-1:0]        div_q,
    output logic [DW-1:0]        div_r
`ifdef HILO_DIV_ZERO_EN
    ,
    output logic                 div_zero
`endif
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;
    logic [DW-1:0] w_hi;
    logic [DW-1:0] w_lo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (wb_mode[1]) r_hi <= wb_hi;
            if (wb_mode[0]) r_lo <= wb_lo;
        end
    end

    // Walk oldest to youngest so the lowest index with a matching bit wins.
    always_comb begin
        w_hi = r_hi;
        w_lo = r_lo;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_mode[2*i+1]) w_hi = fwd_hi[DW*i +: DW];
            if (fwd_mode[2*i])   w_lo = fwd_lo[DW*i +: DW];
        end
    end

    assign real_hilo = {w_hi, w_lo};

    // ex_read only qualifies mux power gating; the forwarded value is independent of it.
    logic w_unused_ex_read;
    assign w_unused_ex_read = ^ex_read;

    state_t          r_state;
    logic [2*DW:0]   r_acc;
    logic [DW-1:0]   r_b;
    logic            r_sign_q;
    logic            r_sign_r;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [DW-1:0]   r_q;
    logic [DW-1:0]   r_r;
`ifdef HILO_DIV_ZERO_EN
    logic            r_zero;
`endif

    logic [2*DW:0]   w_shift;
    logic [DW+1:0]   w_trial;
    logic [2*DW:0]   w_next;
    logic [DW-1:0]   w_abs_a;
    logic [DW-1:0]   w_abs_b;
    logic [DW-1:0]   w_q_fix;
    logic [DW-1:0]   w_r_fix;

    // Partial remainder lives in acc[2*DW:DW], quotient bits shift in at acc[0].
    assign w_shift = r_acc << 1;
    assign w_trial = {1'b0, w_shift[2*DW:DW]} - {2'b00, r_b};
    assign w_next  = w_trial[DW+1] ? w_shift : {w_trial[DW:0], w_shift[DW-1:1], 1'b1};
    assign w_abs_a = (div_signed && div_a[DW-1]) ? -div_a : div_a;
    assign w_abs_b = (div_signed && div_b[DW-1]) ? -div_b : div_b;
    assign w_q_fix = r_sign_q ? -w_next[DW-1:0]    : w_next[DW-1:0];
    assign w_r_fix = r_sign_r ? -w_next[2*DW-1:DW] : w_next[2*DW-1:DW];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_b      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
`ifdef HILO_DIV_ZERO_EN
            r_zero   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef HILO_DIV_ZERO_EN
            r_zero <= 1'b0;
`endif
            if (div_flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (div_start) begin
                            r_acc    <= {{(DW+1){1'b0}}, w_abs_a};
                            r_b      <= w_abs_b;
                            r_sign_q <= div_signed & (div_a[DW-1] ^ div_b[DW-1]);
                            r_sign_r <= div_signed & div_a[DW-1];
                            r_cnt    <= '0;
`ifdef HILO_DIV_ZERO_EN
                            if (div_b == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_zero  <= 1'b1;
                                r_q     <= '1;
                                r_r     <= div_a;
                            end else begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b1;
                            end
`else
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
`endif
                        end
                    end
                    S_RUN: begin
                        r_acc <= w_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(DW - 1)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_q     <= w_q_fix;
                            r_r     <= w_r_fix;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign div_busy = r_busy;
    assign div_done = r_done;
    assign div_q    = r_q;
    assign div_r    = r_r;
`ifdef HILO_DIV_ZERO_EN
    assign div_zero = r_zero;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - scoreboard bench for hilo_unit forwarding, commit and divider.
module tb_hilo_unit;
    localparam int DW   = 32;
    localparam int NFWD = 2;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [1:0]           ex_read;
    logic [2*NFWD-1:0]    fwd_mode;
    logic [DW*NFWD-1:0]   fwd_hi;
    logic [DW*NFWD-1:0]   fwd_lo;
    logic [1:0]           wb_mode;
    logic [DW-1:0]        wb_hi;
    logic [DW-1:0]        wb_lo;
    logic [2*DW-1:0]      real_hilo;
    logic                 div_start;
    logic                 div_signed;
    logic [DW-1:0]        div_a;
    logic [DW-1:0]        div_b;
    logic                 div_flush;
    logic                 div_busy;
    logic                 div_done;
    logic [DW-1:0]        div_q;
    logic [DW-1:0]        div_r;
`ifdef HILO_DIV_ZERO_EN
    logic                 div_zero;
`endif

    always #5 clk = ~clk;

    hilo_unit #(.DW(DW), .NFWD(NFWD)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ex_read    (ex_read),
        .fwd_mode   (fwd_mode),
        .fwd_hi     (fwd_hi),
        .fwd_lo     (fwd_lo),
        .wb_mode    (wb_mode),
        .wb_hi      (wb_hi),
        .wb_lo      (wb_lo),
        .real_hilo  (real_hilo),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_flush  (div_flush),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_q      (div_q),
        .div_r      (div_r)
`ifdef HILO_DIV_ZERO_EN
        ,
        .div_zero   (div_zero)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_div(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] eq, input logic [DW-1:0] er);
        exp_t e;
        e.q = eq;
        e.r = er;
        sb.push_back(e);
        div_signed = sgn;
        div_a      = a;
        div_b      = b;
        div_start  = 1'b1;
        step();
        div_start  = 1'b0;
    endtask

    // Called right after the start edge; optionally fires an extra start mid-run.
    task automatic wait_done(input string tag, input bit inject);
        int   cyc;
        int   busy_n;
        exp_t e;
        cyc    = 1;
        busy_n = 0;
        while (!div_done && cyc < 100) begin
            if (div_busy) busy_n++;
            if (inject && cyc == 5) begin
                div_signed = 1'b0;
                div_a      = 32'd1000;
                div_b      = 32'd3;
                div_start  = 1'b1;
            end
            step();
            div_start = 1'b0;
            cyc++;
        end
        check_eq({tag, "_latency"}, 64'(cyc), 64'(DW + 1));
        check_eq({tag, "_busy_cycles"}, 64'(busy_n), 64'(DW));
        check_eq({tag, "_busy_at_done"}, 64'(div_busy), 64'd0);
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_q"}, 64'(div_q), 64'(e.q));
            check_eq({tag, "_r"}, 64'(div_r), 64'(e.r));
        end
        step();
        check_eq({tag, "_done_pulse"}, 64'(div_done), 64'd0);
    endtask

    initial begin
        logic [DW-1:0]        ua;
        logic [DW-1:0]        ub;
        logic signed [DW-1:0] sa;
        logic signed [DW-1:0] sbv;
        logic [DW-1:0]        q_before;
        bit                   saw_done;

        resetn     = 1'b0;
        ex_read    = 2'b00;
        fwd_mode   = '0;
        fwd_hi     = '0;
        fwd_lo     = '0;
        wb_mode    = 2'b00;
        wb_hi      = '0;
        wb_lo      = '0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_a      = '0;
        div_b      = '0;
        div_flush  = 1'b0;
        repeat (3) step();
        check_eq("rst_hilo", real_hilo, 64'd0);
        check_eq("rst_busy", 64'(div_busy), 64'd0);
        check_eq("rst_done", 64'(div_done), 64'd0);
        check_eq("rst_q", 64'(div_q), 64'd0);
`ifdef HILO_DIV_ZERO_EN
        check_eq("rst_zero", 64'(div_zero), 64'd0);
`endif
        resetn = 1'b1;
        step();

        wb_mode = 2'b11;
        wb_hi   = 32'h5555_5555;
        wb_lo   = 32'h6666_6666;
        step();
        wb_mode = 2'b00;
        check_eq("pre_commit", real_hilo, 64'h5555_5555_6666_6666);

        start_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        void'(sb.pop_back());
        repeat (4) step();
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_busy", 64'(div_busy), 64'd0);
        check_eq("mid_rst_done", 64'(div_done), 64'd0);
        check_eq("mid_rst_hilo", real_hilo, 64'd0);
        step();
        resetn = 1'b1;
        step();

        wb_mode = 2'b11;
        wb_hi   = 32'h1111_1111;
        wb_lo   = 32'h2222_2222;
        step();
        wb_mode = 2'b00;
        check_eq("commit_both", real_hilo, 64'h1111_1111_2222_2222);
        wb_mode = 2'b01;
        wb_hi   = 32'hDEAD_BEEF;
        wb_lo   = 32'h3333_3333;
        step();
        wb_mode = 2'b00;
        check_eq("commit_lo_only", real_hilo, 64'h1111_1111_3333_3333);

        fwd_mode = 4'b10_01;
        fwd_lo   = {32'h0, 32'hAAAA_0000};
        fwd_hi   = {32'hBBBB_0000, 32'h0};
        #1;
        check_eq("fwd_split", real_hilo, 64'hBBBB_0000_AAAA_0000);
        ex_read = 2'b11;
        #1;
        check_eq("fwd_split_read", real_hilo, 64'hBBBB_0000_AAAA_0000);
        ex_read  = 2'b00;
        fwd_mode = 4'b11_11;
        fwd_hi   = {32'd3, 32'd1};
        fwd_lo   = {32'd4, 32'd2};
        #1;
        check_eq("fwd_priority", real_hilo, {32'd1, 32'd2});
        fwd_mode = 4'b11_10;
        #1;
        check_eq("fwd_mixed", real_hilo, {32'd1, 32'd4});
        fwd_mode = 4'b00_00;
        #1;
        check_eq("fwd_none", real_hilo, 64'h1111_1111_3333_3333);

        start_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        wait_done("divu_100_7", 1'b1);
        start_div(1'b1, -32'sd7, 32'sd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        wait_done("div_m7_2", 1'b0);
        start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        wait_done("div_ovf", 1'b0);

        for (int k = 0; k < 3; k++) begin
            ua = $urandom;
            ub = $urandom_range(1, 100000);
            start_div(1'b0, ua, ub, ua / ub, ua % ub);
            wait_done("divu_rand", 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            sa  = $signed($urandom);
            sbv = $signed(32'($urandom_range(1, 5000)));
            if (k != 1) sbv = -sbv;
            start_div(1'b1, sa, sbv, sa / sbv, sa % sbv);
            wait_done("div_rand", 1'b0);
        end

        q_before   = div_q;
        div_signed = 1'b0;
        div_a      = 32'd1000;
        div_b      = 32'd3;
        div_start  = 1'b1;
        step();
        div_start  = 1'b0;
        repeat (10) step();
        div_flush  = 1'b1;
        div_start  = 1'b1;
        step();
        div_flush  = 1'b0;
        div_start  = 1'b0;
        check_eq("flush_busy", 64'(div_busy), 64'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (div_done) saw_done = 1'b1;
            step();
        end
        check_eq("flush_no_done", 64'(saw_done), 64'd0);
        check_eq("flush_q_held", 64'(div_q), 64'(q_before));

`ifdef HILO_DIV_ZERO_EN
        div_signed = 1'b0;
        div_a      = 32'd5;
        div_b      = 32'd0;
        div_start  = 1'b1;
        step();
        div_start  = 1'b0;
        check_eq("dz_done", 64'(div_done), 64'd1);
        check_eq("dz_zero", 64'(div_zero), 64'd1);
        check_eq("dz_q", 64'(div_q), 64'hFFFF_FFFF);
        check_eq("dz_r", 64'(div_r), 64'd5);
        step();
        check_eq("dz_zero_pulse", 64'(div_zero), 64'd0);
`endif

        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
